// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART boot loader: state encoding, default frame start byte
// and the largest word count a frame may carry for a given RAM address width.
package uart_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CKSUM = 3'd4,
        ST_ERR   = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

    // A frame may fill the whole RAM exactly once, so 2^aw words is still legal.
    function automatic logic [32:0] max_words(input int unsigned aw);
        return 33'd1 << aw;
    endfunction

endpackage

// File: rtl/uart_loader_if.sv
// Byte handshake from uart_rx plus the RAM write port, bundled for the boot loader.
// master = loader side, slave = receiver/RAM side.
interface uart_loader_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [7:0]            rx_data;
    logic                  rx_full;
    logic                  rx_re;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_ready;

    modport master (
        input  rx_data, rx_full, mem_ready,
        output rx_re, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output rx_data, rx_full, mem_ready,
        input  rx_re, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/uart_loader_word_asm.sv
// Little-endian byte-to-word packer: bytes shift in from the top so the first byte
// ends up in bits [7:0]. word_next/word_valid present the completed word on its 4th byte.
module uart_loader_word_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        word_valid
);
    logic [1:0]  idx;
    logic [31:0] shreg;

    assign word_next  = {byte_in, shreg[31:8]};
    assign word_valid = byte_en && (idx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx <= 2'd0;
        end else if (byte_en) begin
            idx <= idx + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (byte_en) begin
            shreg <= word_next;
        end
    end

endmodule

// File: rtl/uart_loader.sv
// Boot loader: holds the CPU in reset, parses A5 | LEN(4) | DATA words from uart_rx and
// writes them to RAM, then releases the CPU. Define UART_LOADER_CKSUM_EN for a trailing XOR byte.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter logic [7:0]            MAGIC        = MAGIC_DEFAULT,
    parameter int unsigned           TIMEOUT_CLKS = 1_000_000
) (
    input  logic          clk,
    input  logic          rst,
    uart_loader_if.master bus,
    output logic          cpu_rst,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam logic [32:0] MAX_WORDS = max_words(ADDR_WIDTH);
    localparam logic [31:0] TOUT_LAST = 32'(TIMEOUT_CLKS - 1);
`ifdef UART_LOADER_CKSUM_EN
    localparam state_t ST_FINAL = ST_CKSUM;
`else
    localparam state_t ST_FINAL = ST_DONE;
`endif

    state_t      state, state_nx;
    logic [32:0] remain;
    logic [31:0] tcnt;
    logic        accept, timed, byte_en, tout;
    logic        word_valid;
    logic [31:0] word_next;
`ifdef UART_LOADER_CKSUM_EN
    logic [7:0]  xsum;
`endif

    always_comb begin
        accept  = bus.rx_full && (state inside {ST_IDLE, ST_LEN, ST_DATA, ST_CKSUM});
        timed   = state inside {ST_LEN, ST_DATA, ST_CKSUM};
        byte_en = accept && (state inside {ST_LEN, ST_DATA});
        tout    = (TIMEOUT_CLKS != 0) && timed && !accept && (tcnt == TOUT_LAST);
    end

    assign bus.rx_re  = accept;
    assign bus.mem_we = (state == ST_WRITE);
    assign cpu_rst    = (state != ST_DONE);
    assign done       = (state == ST_DONE);
    assign busy       = !(state inside {ST_IDLE, ST_DONE});

    uart_loader_word_asm u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (state == ST_IDLE),
        .byte_en    (byte_en),
        .byte_in    (bus.rx_data),
        .word_next  (word_next),
        .word_valid (word_valid)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept && bus.rx_data == MAGIC) state_nx = ST_LEN;
            end
            ST_LEN: begin
                if (tout) begin
                    state_nx = ST_ERR;
                end else if (word_valid) begin
                    if (word_next == 32'd0)                    state_nx = ST_FINAL;
                    else if ({1'b0, word_next} > MAX_WORDS)    state_nx = ST_ERR;
                    else                                       state_nx = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tout)            state_nx = ST_ERR;
                else if (word_valid) state_nx = ST_WRITE;
            end
            ST_WRITE: begin
                if (bus.mem_ready) state_nx = (remain == 33'd1) ? ST_FINAL : ST_DATA;
            end
`ifdef UART_LOADER_CKSUM_EN
            ST_CKSUM: begin
                if (tout)        state_nx = ST_ERR;
                else if (accept) state_nx = (bus.rx_data == xsum) ? ST_DONE : ST_ERR;
            end
`endif
            ST_ERR:  state_nx = ST_IDLE;
            ST_DONE: state_nx = ST_DONE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            err           <= 1'b0;
            bus.mem_addr  <= BASE_ADDR;
            bus.mem_wdata <= 32'd0;
            remain        <= 33'd0;
            tcnt          <= 32'd0;
        end else begin
            state <= state_nx;
            // Idle-time counter only runs while waiting on the UART inside a frame.
            tcnt  <= (!timed || accept) ? 32'd0 : tcnt + 32'd1;
            if (state == ST_IDLE && accept && bus.rx_data == MAGIC) err <= 1'b0;
            if (state == ST_ERR) begin
                err          <= 1'b1;
                bus.mem_addr <= BASE_ADDR;
            end
            if (state == ST_LEN && word_valid)  remain        <= {1'b0, word_next};
            if (state == ST_DATA && word_valid) bus.mem_wdata <= word_next;
            if (state == ST_WRITE && bus.mem_ready) begin
                bus.mem_addr <= bus.mem_addr + 1'b1;
                remain       <= remain - 33'd1;
            end
        end
    end

`ifdef UART_LOADER_CKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            xsum <= 8'd0;
        end else if (state == ST_IDLE && accept && bus.rx_data == MAGIC) begin
            xsum <= 8'd0;
        end else if (byte_en) begin
            xsum <= xsum ^ bus.rx_data;
        end
    end
`endif

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: frame table plus hand-written stall, timeout and reset sequences;
// RAM writes are checked against a scoreboard queue filled as data bytes are driven.
module tb_uart_loader;
    import uart_loader_pkg::*;

    localparam int           AW   = 4;
    localparam logic [AW-1:0] BASE = 4'd14;
    localparam int           TO   = 40;
`ifdef UART_LOADER_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic cpu_rst, busy, done, err;

    uart_loader_if #(.ADDR_WIDTH(AW)) bus ();

    uart_loader #(
        .ADDR_WIDTH   (AW),
        .BASE_ADDR    (BASE),
        .MAGIC        (8'hA5),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .cpu_rst (cpu_rst),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;
    wr_t exp_q[$];
    logic [7:0] ck;

    typedef struct packed {
        logic [31:0] n;
        logic [95:0] w;
        logic        bad_ck;
    } frame_t;
    frame_t frames[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted RAM write must match the oldest pending expectation.
    always begin
        @(negedge clk);
        #2;
        if (rst === 1'b0 && bus.mem_we === 1'b1 && bus.mem_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h with none expected",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 64'(bus.mem_addr), 64'(e.addr));
                check("write_data", 64'(bus.mem_wdata), 64'(e.data));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.rx_data = b;
        bus.rx_full = 1'b1;
        #1;
        while (bus.rx_re !== 1'b1 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (bus.rx_re !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL byte_taken: byte %0h rx_re=%b after %0d cycles", b, bus.rx_re, n);
        end
        @(negedge clk);
        bus.rx_full = 1'b0;
    endtask

    task automatic send_ck(input logic [7:0] b);
        ck = ck ^ b;
        send_byte(b);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_ck(w[i*8 +: 8]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.rx_full = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        ck = 8'd0;
    endtask

    // Drives a whole frame; words go to the scoreboard only when the length is legal.
    task automatic send_frame(input logic [31:0] n, input logic [95:0] w, input logic bad);
        bit len_ok;
        len_ok = (n <= 32'd16);
        send_byte(8'hA5);
        ck = 8'd0;
        send_word(n);
        if (len_ok) begin
            for (int i = 0; i < 3 && i < int'(n); i++) begin
                exp_q.push_back('{addr: BASE + AW'(i), data: w[i*32 +: 32]});
                send_word(w[i*32 +: 32]);
            end
            if (CK) send_byte(bad ? (ck ^ 8'h01) : ck);
        end
    endtask

    task automatic finish_check(input bit exp_err, input logic [AW-1:0] exp_addr);
        int t;
        t = 0;
        while (!(done || err) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!(done || err)) begin
            checks++;
            errors++;
            $display("FAIL frame_end: done=%b err=%b after %0d cycles", done, err, t);
        end
        #1;
        check("done", 64'(done), 64'(!exp_err));
        check("err", 64'(err), 64'(exp_err));
        check("cpu_rst", 64'(cpu_rst), 64'(exp_err));
        check("busy", 64'(busy), 64'd0);
        check("writes_left", 64'(exp_q.size()), 64'd0);
        check("mem_addr_end", 64'(bus.mem_addr), 64'(exp_addr));
        if (!exp_err) begin
            bus.rx_data = 8'hA5;
            bus.rx_full = 1'b1;
            #1;
            check("rx_re_done", 64'(bus.rx_re), 64'd0);
            bus.rx_full = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.rx_full = 1'b0;
        bus.rx_data = 8'h00;
        bus.mem_ready = 1'b1;
        ck = 8'd0;

        frames[0] = '{n: 32'd2, w: {32'h0, 32'h88776655, 32'h44332211}, bad_ck: 1'b0};
        frames[1] = '{n: 32'd0, w: 96'h0, bad_ck: 1'b0};
        frames[2] = '{n: 32'd3, w: {32'hC0C0C0C0, 32'hB0B1B2B3, 32'hA0A1A2A3}, bad_ck: 1'b0};
        frames[3] = '{n: 32'd17, w: 96'h0, bad_ck: 1'b0};
        frames[4] = '{n: 32'h8000_0001, w: 96'h0, bad_ck: 1'b0};
        frames[5] = '{n: 32'd2, w: {32'h0, 32'h88776655, 32'h44332211}, bad_ck: 1'b1};

        do_reset();
        #1;
        check("reset_ctrl", 64'({cpu_rst, bus.rx_re, bus.mem_we, busy, done, err}), 64'b100000);
        check("reset_addr", 64'(bus.mem_addr), 64'(BASE));
        check("reset_wdata", 64'(bus.mem_wdata), 64'd0);
        @(negedge clk);

        for (int f = 0; f < 6; f++) begin
            bit e;
            logic [AW-1:0] ea;
            e  = (frames[f].n > 32'd16) || (CK && frames[f].bad_ck);
            ea = e ? BASE : BASE + AW'(frames[f].n);
            do_reset();
            bus.rx_data = 8'h00;
            send_byte(8'h00);
            send_frame(frames[f].n, frames[f].w, frames[f].bad_ck);
            finish_check(e, ea);
        end

        // RAM stall during the first write: outputs frozen, UART byte left waiting.
        do_reset();
        bus.mem_ready = 1'b0;
        send_byte(8'hA5);
        ck = 8'd0;
        send_word(32'd2);
        exp_q.push_back('{addr: BASE, data: 32'h44332211});
        exp_q.push_back('{addr: BASE + AW'(1), data: 32'h88776655});
        send_word(32'h44332211);
        bus.rx_data = 8'h55;
        bus.rx_full = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("stall_hold", 64'({bus.mem_we, bus.rx_re, bus.mem_addr, bus.mem_wdata}),
                  64'({1'b1, 1'b0, BASE, 32'h44332211}));
            @(negedge clk);
        end
        bus.mem_ready = 1'b1;
        send_ck(8'h55);
        send_ck(8'h66);
        send_ck(8'h77);
        send_ck(8'h88);
        if (CK) send_byte(ck);
        finish_check(1'b0, BASE + AW'(2));

        // Inter-byte timeout with a partial word, then recovery without reset.
        do_reset();
        send_byte(8'hA5);
        ck = 8'd0;
        send_word(32'd1);
        send_ck(8'hDE);
        send_ck(8'hAD);
        repeat (TO - 1) @(negedge clk);
        #1;
        check("tout_before", 64'({busy, err}), 64'b10);
        repeat (2) @(negedge clk);
        #1;
        check("tout_after", 64'({busy, err, cpu_rst, done}), 64'b0110);
        check("tout_addr", 64'(bus.mem_addr), 64'(BASE));
        @(negedge clk);
        send_byte(8'hA5);
        #1;
        check("err_clear", 64'(err), 64'd0);
        @(negedge clk);
        ck = 8'd0;
        send_word(32'd1);
        exp_q.push_back('{addr: BASE, data: 32'h01020304});
        send_word(32'h01020304);
        if (CK) send_byte(ck);
        finish_check(1'b0, BASE + AW'(1));

        // Reset mid-DATA, then garbage before a fresh frame.
        do_reset();
        send_byte(8'hA5);
        ck = 8'd0;
        send_word(32'd2);
        send_ck(8'h11);
        send_ck(8'h22);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_ctrl", 64'({cpu_rst, bus.rx_re, bus.mem_we, busy, done, err}), 64'b100000);
        check("midrst_addr", 64'(bus.mem_addr), 64'(BASE));
        check("midrst_wdata", 64'(bus.mem_wdata), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'hFF);
        send_byte(8'h5A);
        #1;
        check("garbage_idle", 64'({busy, err, done}), 64'b000);
        @(negedge clk);
        send_frame(32'd1, {64'h0, 32'hCAFEF00D}, 1'b0);
        finish_check(1'b0, BASE + AW'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
